led_shift_out: RTL and testbench
================================

Name: led_shift_out

Overview:
- Serialiser downstream of the LED output register: consumes its 8-bit parallel value and drives an external 74HC595-style shift register (SER/SCLK/RCLK).
- The parallel LED register can then live on a board with few free pins.
- Detects value changes autonomously, shifts the new value out MSB-first, pulses the latch, and reports busy.
- Sits between the LED register output and the top-level pins.

Parameters:
- DATA_WIDTH, 8, width of the parallel value and number of bits shifted per transfer.
- CLK_DIV, 2, clk cycles per SCLK phase (low phase and high phase each last CLK_DIV cycles); legal range ≥1.
- REFRESH_PERIOD, 1000000, clk cycles between forced re-sends (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  DATA_WIDTH  parallel LED value from the LED register output.
- load  input  1  single-cycle strobe; forces a transfer of din even if unchanged (tie to the LED register's write enable).
- busy  output  1  high while a transfer is in progress.
- ser  output  1  serial data to shift register.
- sclk  output  1  shift clock; external device samples ser on the rising edge.
- rclk  output  1  storage-register latch pulse.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, ser=0, sclk=0, rclk=0.
  - shadow register=0; pending=0; init flag=1.
- States: IDLE, SHIFT, LATCH.
- IDLE start condition: (din != shadow) OR load OR pending OR init. When true, in that cycle:
  - shreg<=din, shadow<=din, bitcnt<=0, divcnt<=0.
  - pending<=0, init<=0.
  - Go to SHIFT; busy=1 from the next cycle.
- The init flag guarantees that one transfer of the current din starts in the first cycle after reset release, even if din=0.
- SHIFT:
  - ser=shreg[DATA_WIDTH-1] and is stable for the whole bit.
  - sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles.
  - At the end of the high phase: shreg shifts left by 1, bitcnt increments.
  - After bit DATA_WIDTH-1 completes: sclk<=0, go to LATCH.
- LATCH:
  - rclk=1 for CLK_DIV cycles; sclk=0; ser holds its last value.
  - Then rclk<=0, busy<=0, go to IDLE.
- Timing: busy is high for exactly 2*CLK_DIV*DATA_WIDTH + CLK_DIV cycles. Defaults give 34 cycles.
- Back-to-back transfers: a start condition present on return to IDLE begins the next transfer in that IDLE cycle, giving exactly one busy=0 cycle between transfers.
- din is sampled only at capture. Changes during a transfer are not lost: on return to IDLE, shadow != din triggers a new transfer. Multiple changes during one transfer coalesce to the latest value.
- load during SHIFT/LATCH sets pending=1. load in the capture cycle itself is absorbed by that capture.
- din changing and load arriving in the same IDLE cycle produce one transfer only.
- Reset mid-transfer: outputs drop to 0 immediately. The partial frame is abandoned, and init forces a full re-send after release.
- sclk and rclk are never high simultaneously. No glitches: all outputs are registered.

Optional Feature:
- Macro LED_SHIFT_REFRESH_EN.
- Defined:
  - A free-running counter counts clk cycles while in IDLE.
  - On reaching REFRESH_PERIOD-1 it sets pending=1 and clears.
  - It also clears whenever any transfer starts.
  - This re-sends shadow/din periodically to recover from external corruption.
- Not defined: no counter is instantiated, and transfers occur only on change, load, or init.

Test Plan:
- Reset release with din=8'h00, CLK_DIV=2 -> one transfer starts in the first cycle after release; eight sclk rising edges with ser=0; one rclk pulse 2 cycles wide; busy high 34 cycles, then low.
- din=8'hA5 in IDLE -> ser across sclk rising edges = 1,0,1,0,0,1,0,1; rclk pulses once after the 8th edge; model register reads 8'hA5.
- din 8'h01 -> 8'h3C -> 8'hFF during one transfer (all after capture) -> after the 8'h01 frame, one idle cycle, then exactly one more transfer of 8'hFF; no 8'h3C frame.
- load pulsed with unchanged din=8'h5A, once in IDLE and once mid-transfer -> two 8'h5A frames total, the second starting one cycle after busy falls.
- rst_n asserted at bit 4 of an 8'hC3 transfer -> sclk/rclk/ser/busy 0 in the same cycle; after release, a full 8'hC3 frame; model never latches a partial value.
- With LED_SHIFT_REFRESH_EN, REFRESH_PERIOD=100, din constant 8'h81 -> frames repeat every 100 idle cycles plus frame length. Without the macro -> no frame after the initial one.

Source files
------------

// File: rtl/led_shift_out.sv
// Serialises a parallel LED value into a 74HC595-style shift register (SER/SCLK/RCLK).
// Optional periodic re-send is enabled by defining LED_SHIFT_REFRESH_EN.
module led_shift_out #(
  parameter int DATA_WIDTH     = 8,
  parameter int CLK_DIV        = 2,
  parameter int REFRESH_PERIOD = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  load,
  output logic                  busy,
  output logic                  ser,
  output logic                  sclk,
  output logic                  rclk
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;

  localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LO_END = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HI_END = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_WIDTH - 1);

  if (CLK_DIV < 1 || REFRESH_PERIOD < 1) begin : g_bad_param
    $error("led_shift_out: CLK_DIV and REFRESH_PERIOD must be >= 1");
  end

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
  logic [DIV_W-1:0]      divcnt_q, divcnt_d;
  logic                  pending_q, pending_d;
  logic                  init_q, init_d;
  logic                  busy_q, busy_d;
  logic                  ser_q, ser_d;
  logic                  sclk_q, sclk_d;
  logic                  rclk_q, rclk_d;
  logic                  start;
  logic                  refresh_hit;

`ifdef LED_SHIFT_REFRESH_EN
  localparam int REF_W = $clog2(REFRESH_PERIOD + 1);
  localparam logic [REF_W-1:0] REF_END = REF_W'(REFRESH_PERIOD - 1);
  logic [REF_W-1:0] refcnt_q, refcnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) refcnt_q <= '0;
    else        refcnt_q <= refcnt_d;
  end

  // Counter only advances in IDLE; any transfer start restarts the period.
  always_comb begin
    refcnt_d    = refcnt_q;
    refresh_hit = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        refcnt_d = '0;
      end else if (refcnt_q == REF_END) begin
        refcnt_d    = '0;
        refresh_hit = 1'b1;
      end else begin
        refcnt_d = refcnt_q + REF_W'(1);
      end
    end
  end
`else
  assign refresh_hit = 1'b0;
`endif

  assign start = (din != shadow_q) | load | pending_q | init_q;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    shadow_d  = shadow_q;
    bitcnt_d  = bitcnt_q;
    divcnt_d  = divcnt_q;
    pending_d = pending_q | refresh_hit;
    init_d    = init_q;
    busy_d    = busy_q;
    ser_d     = ser_q;
    sclk_d    = sclk_q;
    rclk_d    = rclk_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d   = din;
          shadow_d  = din;
          bitcnt_d  = '0;
          divcnt_d  = '0;
          pending_d = 1'b0;
          init_d    = 1'b0;
          busy_d    = 1'b1;
          ser_d     = din[DATA_WIDTH-1];
          sclk_d    = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (load) pending_d = 1'b1;
        divcnt_d = divcnt_q + DIV_W'(1);
        if (divcnt_q == DIV_LO_END) sclk_d = 1'b1;
        // ser is pre-loaded with the next MSB at the same edge sclk falls.
        if (divcnt_q == DIV_HI_END) begin
          divcnt_d = '0;
          sclk_d   = 1'b0;
          shreg_d  = shreg_q << 1;
          bitcnt_d = bitcnt_q + CNT_W'(1);
          ser_d    = shreg_d[DATA_WIDTH-1];
          if (bitcnt_q == LAST_BIT) begin
            ser_d   = ser_q;
            rclk_d  = 1'b1;
            state_d = LATCH;
          end
        end
      end
      LATCH: begin
        if (load) pending_d = 1'b1;
        divcnt_d = divcnt_q + DIV_W'(1);
        if (divcnt_q == DIV_LO_END) begin
          divcnt_d = '0;
          rclk_d   = 1'b0;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      shadow_q  <= '0;
      bitcnt_q  <= '0;
      divcnt_q  <= '0;
      pending_q <= 1'b0;
      init_q    <= 1'b1;
      busy_q    <= 1'b0;
      ser_q     <= 1'b0;
      sclk_q    <= 1'b0;
      rclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      shadow_q  <= shadow_d;
      bitcnt_q  <= bitcnt_d;
      divcnt_q  <= divcnt_d;
      pending_q <= pending_d;
      init_q    <= init_d;
      busy_q    <= busy_d;
      ser_q     <= ser_d;
      sclk_q    <= sclk_d;
      rclk_q    <= rclk_d;
    end
  end

  assign busy = busy_q;
  assign ser  = ser_q;
  assign sclk = sclk_q;
  assign rclk = rclk_q;

endmodule

// File: tb/tb_led_shift_out.sv
// Scoreboard bench for led_shift_out: a transaction-level model predicts frames and busy;
// a behavioural 74HC595 model rebuilds each latched value from ser/sclk/rclk.
module tb_led_shift_out;
  localparam int DW    = 8;
  localparam int CD    = 2;
  localparam int FRAME = 2 * CD * DW + CD;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          load  = 1'b0;
  logic [DW-1:0] din   = '0;
  logic          busy, ser, sclk, rclk;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  led_shift_out #(.DATA_WIDTH(DW), .CLK_DIV(CD), .REFRESH_PERIOD(100)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .load(load),
    .busy(busy), .ser(ser), .sclk(sclk), .rclk(rclk)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a fixed-length busy window; requests seen while busy
  // are remembered as one pending re-send, value changes are picked up at the next idle.
  logic [DW-1:0] exp_q[$];
  int            m_left    = 0;
  logic [DW-1:0] m_shadow  = '0;
  bit            m_pending = 1'b0;
  bit            m_init    = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (m_left > 0 && exp_q.size() > 0) void'(exp_q.pop_back());
      m_left = 0; m_shadow = '0; m_pending = 1'b0; m_init = 1'b1;
    end else if (m_left == 0) begin
      if (din !== m_shadow || load || m_pending || m_init) begin
        exp_q.push_back(din);
        m_shadow = din; m_pending = 1'b0; m_init = 1'b0; m_left = FRAME;
      end
    end else begin
      if (load) m_pending = 1'b1;
      m_left--;
    end
  end

  // External shift register model + monitor.
  logic [DW-1:0] ext_sr;
  int            ext_bits = 0;
  logic          sclk_p = 1'b0, rclk_p = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ext_bits = 0; sclk_p = 1'b0; rclk_p = 1'b0;
    end else begin
      if (sclk && !sclk_p) begin
        ext_sr = {ext_sr[DW-2:0], ser};
        ext_bits++;
      end
      if (rclk && !rclk_p) begin
        check("frame_bits", ext_bits, DW);
        if (exp_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL unexpected_frame: got %0h expected none at %0t", ext_sr, $time);
        end else begin
          check("frame_value", ext_sr, exp_q.pop_front());
        end
        ext_bits = 0;
      end
      check("busy", busy, m_left > 0);
      check("sclk_rclk_excl", sclk & rclk, 0);
      sclk_p = sclk; rclk_p = rclk;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle;
    int t = 0;
    while (!(m_left == 0 && din === m_shadow && !m_pending && !m_init) && t < 500) begin
      @(negedge clk);
      t++;
    end
    cyc(2);
    if (t >= 500) begin
      vectors++; errors++;
      $display("FAIL wait_idle_timeout: got %0d cycles expected < 500", t);
    end
  endtask

  task automatic check_outputs_low(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ser"},  ser,  0);
    check({tag, "_sclk"}, sclk, 0);
    check({tag, "_rclk"}, rclk, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_outputs_low("reset");
    cyc(3);
    rst_n = 1'b1;
    wait_idle();

    din = 8'hA5;
    wait_idle();

    din = 8'h01;
    cyc(3);
    din = 8'h3C;
    cyc(5);
    din = 8'hFF;
    wait_idle();

    din = 8'h5A;
    wait_idle();
    pulse_load();
    cyc(10);
    pulse_load();
    wait_idle();

    din = 8'hC3;
    cyc(18);
    #2 rst_n = 1'b0;
    #1 check_outputs_low("midreset");
    cyc(2);
    #2 rst_n = 1'b1;
    wait_idle();

    din  = 8'h66;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    wait_idle();

    for (int i = 0; i < 25; i++) begin
      int unsigned r;
      r = $urandom;
      cyc($urandom_range(0, 45));
      if (r % 4 != 0) din = DW'($urandom);
      if (r % 3 == 0) pulse_load();
    end
    wait_idle();

    cyc(300);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
